// File: rtl/l2_pool_pkg.sv
// l2_pool_pkg: shared types and default geometry for the layer_2 max-pool stage.
//   state_t    : two-state control FSM (FILL accepts beats, DRAIN empties the frame).
//   L2_*       : default data width, window geometry and FIFO depth.
//   FRAME_OUT  : pooled values delivered per frame (positions x channels).
package l2_pool_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int L2_DW     = 18;
    localparam int L2_NCH    = 4;
    localparam int L2_WIN    = 4;
    localparam int L2_NPOS   = 25;
    localparam int L2_DEPTH  = 8;
    localparam int FRAME_OUT = L2_NPOS * L2_NCH;

endpackage

// File: rtl/pool_fifo.sv
// pool_fifo: synchronous FIFO holding pooled results until downstream takes them.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   clr        : synchronous clear of pointers/count, wins over push and pop
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   dout       : head entry, forced to 0 while empty
//   empty/full : occupancy flags; count : entries held (0..DEPTH)
module pool_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign empty   = (count_r == {(AW+1){1'b0}});
    assign full    = (count_r == (AW+1)'(DEPTH));
    assign count   = count_r;
    assign wr_en_s = push && !full && !clr;
    assign rd_en_s = pop && !empty && !clr;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head of queue, masked so stale storage never leaks out while empty.
    always_comb begin
        if (empty) begin
            dout = {DW{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/l2_pool.sv
// l2_pool: 2x2 max-pool stage behind layer_2.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tx_done     : synchronous frame abort/clear shared with layer_2
//   din_vld/din : input beat (element-major, channel-minor), in_rdy accepts it
//   dout/dout_vld/dout_rdy : pooled output stream from the FIFO head
//   frame_done  : one-cycle pulse on the pop of the last pooled value of a frame
module l2_pool
    import l2_pool_pkg::*;
#(
    parameter int DW    = L2_DW,
    parameter int NCH   = L2_NCH,
    parameter int WIN   = L2_WIN,
    parameter int NPOS  = L2_NPOS,
    parameter int DEPTH = L2_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_done,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    output logic          in_rdy,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          frame_done
);

    localparam int CW = $clog2(NCH);
    localparam int EW = $clog2(WIN);
    localparam int PW = $clog2(NPOS);
    localparam int FO = NPOS * NCH;
    localparam int OW = $clog2(FO);
    localparam int AW = $clog2(DEPTH);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] ch_cnt_r;
    logic [EW-1:0] elem_cnt_r;
    logic [PW-1:0] pos_cnt_r;
    logic [OW-1:0] pop_cnt_r;
    logic [DW-1:0] max_r [NCH];

    logic          accept_s;
    logic          beat_s;
    logic          last_elem_s;
    logic          last_ch_s;
    logic          last_pos_s;
    logic          last_pop_s;
    logic          win_end_s;
    logic [DW-1:0] max_sel_s;
    logic          push_s;
    logic          pop_s;
    logic          in_rdy_s;
    logic          frame_done_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [AW:0]   fifo_count_s;

    assign last_elem_s = (elem_cnt_r == EW'(WIN - 1));
    assign last_ch_s   = (ch_cnt_r == CW'(NCH - 1));
    assign last_pos_s  = (pos_cnt_r == PW'(NPOS - 1));
    assign last_pop_s  = (pop_cnt_r == OW'(FO - 1));
    // Readiness deliberately ignores a same-cycle pop.
    assign in_rdy_s    = (state_r == FILL) && (fifo_count_s < (AW+1)'(DEPTH));
    assign accept_s    = din_vld && in_rdy_s;
    // tx_done discards any beat or pop presented in the same cycle.
    assign beat_s      = accept_s && !tx_done;
    assign win_end_s   = beat_s && last_elem_s && last_ch_s;
    assign max_sel_s   = (din > max_r[ch_cnt_r]) ? din : max_r[ch_cnt_r];
    assign push_s      = beat_s && last_elem_s && !fifo_full_s;
    assign pop_s       = !fifo_empty_s && dout_rdy && !tx_done;
    assign frame_done_s = (state_r == DRAIN) && pop_s && last_pop_s;

    assign in_rdy     = in_rdy_s;
    assign dout_vld   = !fifo_empty_s;
    assign frame_done = frame_done_s;

    pool_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tx_done),
        .push  (push_s),
        .din   (max_sel_s),
        .pop   (pop_s),
        .dout  (dout),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: stop taking beats after the final window until the frame drains.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                if (win_end_s && last_pos_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DRAIN: begin
                if (frame_done_s) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = FILL;
        endcase
        if (tx_done) begin
            state_nxt_s = FILL;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Beat, window and pop counters; channel wraps into element, window end bumps position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_r   <= {CW{1'b0}};
            elem_cnt_r <= {EW{1'b0}};
            pos_cnt_r  <= {PW{1'b0}};
            pop_cnt_r  <= {OW{1'b0}};
        end else if (tx_done) begin
            ch_cnt_r   <= {CW{1'b0}};
            elem_cnt_r <= {EW{1'b0}};
            pos_cnt_r  <= {PW{1'b0}};
            pop_cnt_r  <= {OW{1'b0}};
        end else begin
            if (beat_s) begin
                if (last_ch_s) begin
                    ch_cnt_r   <= {CW{1'b0}};
                    elem_cnt_r <= last_elem_s ? {EW{1'b0}} : elem_cnt_r + EW'(1'b1);
                end else begin
                    ch_cnt_r   <= ch_cnt_r + CW'(1'b1);
                end
            end
            if (frame_done_s) begin
                pos_cnt_r <= {PW{1'b0}};
                pop_cnt_r <= {OW{1'b0}};
            end else begin
                if (win_end_s) begin
                    pos_cnt_r <= last_pos_s ? {PW{1'b0}} : pos_cnt_r + PW'(1'b1);
                end
                if (pop_s) begin
                    pop_cnt_r <= pop_cnt_r + OW'(1'b1);
                end
            end
        end
    end

    // Running per-channel maximum; element 0 reloads it, so tx_done need not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                max_r[i] <= {DW{1'b0}};
            end
        end else if (beat_s && !last_elem_s) begin
            if (elem_cnt_r == {EW{1'b0}}) begin
                max_r[ch_cnt_r] <= din;
            end else begin
                max_r[ch_cnt_r] <= max_sel_s;
            end
        end
    end

endmodule

// File: tb/tb_l2_pool.sv
module tb_l2_pool;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_done;
    logic        din_vld;
    logic [17:0] din;
    logic        in_rdy;
    logic [17:0] dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] beat_q[$];
    logic [17:0] exp_q[$];

    l2_pool dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_done    (tx_done),
        .din_vld    (din_vld),
        .din        (din),
        .in_rdy     (in_rdy),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_rdy   (dout_rdy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        tx_done  = 1'b1;
        din_vld  = 1'b0;
        dout_rdy = 1'b0;
        tick();
        tx_done = 1'b0;
    endtask

    function automatic logic [17:0] rnd_val();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 18'h0;
        if (r == 1) return 18'h3FFFF;
        if (r == 2) return 18'($urandom_range(0, 3));
        return 18'($urandom);
    endfunction

    // Append nwin random windows: beats in element-major order, expected maxima per channel.
    task automatic gen_frame(input int nwin);
        logic [17:0] v[4][4];
        logic [17:0] m;
        for (int w = 0; w < nwin; w++) begin
            for (int e = 0; e < 4; e++)
                for (int c = 0; c < 4; c++) begin
                    v[e][c] = rnd_val();
                    beat_q.push_back(v[e][c]);
                end
            for (int c = 0; c < 4; c++) begin
                m = 18'h0;
                for (int e = 0; e < 4; e++) if (v[e][c] > m) m = v[e][c];
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_done = 1'b0; din_vld = 1'b0; din = 18'h0; dout_rdy = 1'b0;
        #12;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_in_rdy got=%b exp=1", in_rdy); end
        n_cmp++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL rst_dout_vld got=%b exp=0", dout_vld); end
        n_cmp++; if (dout !== 18'h0) begin n_err++; $display("FAIL rst_dout got=%h exp=0", dout); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        #5 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_window();
        logic [17:0] bts[16];
        logic [17:0] ex[4];
        bts = '{18'd5, 18'd0, 18'h3FFFF, 18'd4, 18'd9, 18'd0, 18'd1, 18'd4,
                18'd3, 18'd0, 18'd2, 18'd4, 18'd7, 18'd0, 18'd3, 18'd4};
        ex  = '{18'd9, 18'd0, 18'h3FFFF, 18'd4};
        do_clear();
        dout_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            din_vld = 1'b1; din = bts[k];
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL sw_in_rdy k=%0d got=%b exp=1", k, in_rdy); end
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL sw_frame_done k=%0d got=%b exp=0", k, frame_done); end
            tick();
            if (k >= 12) begin
                n_cmp++; if (dout_vld !== 1'b1 || dout !== ex[k-12]) begin
                    n_err++; $display("FAIL sw_dout k=%0d got=%b/%h exp=1/%h", k, dout_vld, dout, ex[k-12]); end
            end else begin
                n_cmp++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL sw_early_vld k=%0d got=%b exp=0", k, dout_vld); end
            end
        end
        din_vld = 1'b0;
        tick();
        n_cmp++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL sw_drained got=%b exp=0", dout_vld); end
    endtask

    task automatic test_backpressure();
        int bi, oi;
        do_clear();
        beat_q.delete(); exp_q.delete(); gen_frame(3);
        for (int k = 0; k < 32; k++) begin
            din_vld = 1'b1; din = beat_q[k];
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_fill k=%0d got=%b exp=1", k, in_rdy); end
            tick();
        end
        din = beat_q[32];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_full k=%0d got=%b exp=0", k, in_rdy); end
            n_cmp++; if (dout_vld !== 1'b1 || dout !== exp_q[0]) begin
                n_err++; $display("FAIL bp_head k=%0d got=%b/%h exp=1/%h", k, dout_vld, dout, exp_q[0]); end
            tick();
        end
        dout_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_vs_pop got=%b exp=0", in_rdy); end
        tick();
        dout_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b1 || dout !== exp_q[1]) begin
            n_err++; $display("FAIL bp_after_pop got=%b/%h exp=1/%h", in_rdy, dout, exp_q[1]); end
        tick();
        bi = 33; oi = 1;
        dout_rdy = 1'b1;
        for (int cyc = 0; cyc < 80 && !(bi == 48 && oi == 12); cyc++) begin
            din_vld = (bi < 48); din = (bi < 48) ? beat_q[bi] : 18'h0;
            @(negedge clk);
            if (dout_vld) begin
                n_cmp++; if (oi >= 12 || dout !== exp_q[oi]) begin
                    n_err++; $display("FAIL bp_out idx=%0d got=%h exp=%h", oi, dout, (oi < 12) ? exp_q[oi] : 18'h0); end
                oi++;
            end
            if (din_vld && in_rdy) bi++;
            tick();
        end
        din_vld = 1'b0;
        n_cmp++; if (bi != 48 || oi != 12) begin n_err++; $display("FAIL bp_totals got=%0d/%0d exp=48/12", bi, oi); end
        tick();
        n_cmp++; if (dout_vld !== 1'b0) begin n_err++; $display("FAIL bp_extra_out got=%b exp=0", dout_vld); end
    endtask

    // Full frame with random gaps and random backpressure against a queue model.
    task automatic test_full_frame();
        int bi, pops;
        bit drain_m, done_seen, exp_rdy, exp_vld, exp_pop, exp_fd;
        logic [17:0] fq[$];
        logic [17:0] exp_dout;
        beat_q.delete(); exp_q.delete(); gen_frame(25);
        bi = 0; pops = 0; drain_m = 0; done_seen = 0;
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            din_vld  = (bi < 400) && ($urandom_range(0, 9) != 0);
            din      = (bi < 400) ? beat_q[bi] : 18'($urandom);
            dout_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy  = !drain_m && (fq.size() < 8);
            exp_vld  = (fq.size() > 0);
            exp_dout = exp_vld ? fq[0] : 18'h0;
            exp_pop  = exp_vld && dout_rdy;
            exp_fd   = exp_pop && (pops == 99);
            n_cmp++; if (in_rdy !== exp_rdy) begin n_err++; $display("FAIL ff_in_rdy cyc=%0d got=%b exp=%b", cyc, in_rdy, exp_rdy); end
            n_cmp++; if (dout_vld !== exp_vld) begin n_err++; $display("FAIL ff_dout_vld cyc=%0d got=%b exp=%b", cyc, dout_vld, exp_vld); end
            n_cmp++; if (dout !== exp_dout) begin n_err++; $display("FAIL ff_dout cyc=%0d got=%h exp=%h", cyc, dout, exp_dout); end
            n_cmp++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL ff_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
            if (exp_pop) begin
                void'(fq.pop_front());
                pops++;
            end
            if (exp_fd) begin
                drain_m = 0; done_seen = 1;
            end
            if (din_vld && exp_rdy) begin
                if ((bi % 16) >= 12) fq.push_back(exp_q[(bi / 16) * 4 + (bi % 4)]);
                if (bi == 399) drain_m = 1;
                bi++;
            end
            tick();
        end
        din_vld = 1'b0; dout_rdy = 1'b0;
        n_cmp++; if (!done_seen || pops != 100) begin
            n_err++; $display("FAIL ff_frame_end done=%0d pops=%0d exp=1/100", done_seen, pops); end
    endtask

    task automatic test_tx_done();
        do_clear();
        beat_q.delete(); exp_q.delete(); gen_frame(4);
        for (int b = 0; b < 57; b++) begin
            dout_rdy = (b < 32); din_vld = 1'b1; din = beat_q[b];
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL tx_in_rdy b=%0d got=%b exp=1", b, in_rdy); end
            tick();
        end
        tx_done = 1'b1; din_vld = 1'b1; din = beat_q[57]; dout_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (dout_vld !== 1'b1 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL tx_cycle got=%b/%b exp=1/0", dout_vld, frame_done); end
        tick();
        tx_done = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (dout_vld !== 1'b0 || dout !== 18'h0 || in_rdy !== 1'b1) begin
            n_err++; $display("FAIL tx_cleared got=%b/%h/%b exp=0/0/1", dout_vld, dout, in_rdy); end
        tick();
        test_full_frame();
    endtask

    task automatic test_simul_push_pop();
        do_clear();
        beat_q.delete(); exp_q.delete(); gen_frame(3);
        for (int b = 0; b < 31; b++) begin
            din_vld = 1'b1; din = beat_q[b];
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL sp_fill b=%0d got=%b exp=1", b, in_rdy); end
            tick();
        end
        din = beat_q[31]; dout_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b1 || dout_vld !== 1'b1) begin
            n_err++; $display("FAIL sp_pre got=%b/%b exp=1/1", in_rdy, dout_vld); end
        tick();
        din_vld = 1'b0; dout_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b1 || dout !== exp_q[1]) begin
            n_err++; $display("FAIL sp_post got=%b/%h exp=1/%h", in_rdy, dout, exp_q[1]); end
        tick();
        for (int b = 32; b < 45; b++) begin
            din_vld = 1'b1; din = beat_q[b];
            @(negedge clk);
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL sp_count b=%0d got=%b exp=1", b, in_rdy); end
            tick();
        end
        din_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL sp_now_full got=%b exp=0", in_rdy); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        do_clear();
        beat_q.delete(); exp_q.delete(); gen_frame(25);
        dout_rdy = 1'b1;
        for (int b = 0; b < 400; b++) begin
            din_vld = 1'b1; din = beat_q[b];
            @(negedge clk);
            if (b % 50 == 0) begin
                n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rd_in_rdy b=%0d got=%b exp=1", b, in_rdy); end
            end
            tick();
        end
        din_vld = 1'b1; din = 18'h1; dout_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_rdy !== 1'b0 || dout_vld !== 1'b1 || dout !== exp_q[99]) begin
            n_err++; $display("FAIL rd_drain got=%b/%b/%h exp=0/1/%h", in_rdy, dout_vld, dout, exp_q[99]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_rdy !== 1'b1 || dout_vld !== 1'b0 || dout !== 18'h0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL rd_async got=%b/%b/%h/%b exp=1/0/0/0", in_rdy, dout_vld, dout, frame_done); end
        din_vld = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rd_release got=%b exp=1", in_rdy); end
        test_full_frame();
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_backpressure();
        do_clear();
        test_full_frame();
        test_tx_done();
        test_simul_push_pop();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
